// File: rtl/xor_session_ctrl.sv
// Session sequencer for the serial XOR-encryption datapath: validates key/message loads,
// starts encryption, launches the serializer and reports errors. Optional: XSC_KEY_ROTATE_EN.
module xor_session_ctrl #(
  parameter  int KEY_SIZE    = 8,
  parameter  int MSG_SIZE    = 64,
  parameter  int TIMEOUT_CYC = 255,
  parameter  int KEY_USES    = 4,
  localparam int KCW         = $clog2(KEY_SIZE) + 1,
  localparam int MCW         = $clog2(MSG_SIZE) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           clr_i,
  input  logic           key_flag_i,
  input  logic           msg_flag_i,
  input  logic [KCW-1:0] key_cnt_i,
  input  logic [MCW-1:0] msg_cnt_i,
  input  logic           enc_done_i,
  input  logic           ser_busy_i,
  output logic           enc_start_o,
  output logic           ser_start_o,
  output logic           done_o,
  output logic           err_o,
  output logic [2:0]     err_code_o,
  output logic [2:0]     state_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int UW = $clog2(KEY_USES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_KEY = 3'd1;
  localparam logic [2:0] S_WAIT_MSG = 3'd2;
  localparam logic [2:0] S_LOAD_MSG = 3'd3;
  localparam logic [2:0] S_ENCRYPT  = 3'd4;
  localparam logic [2:0] S_SEND     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERROR    = 3'd7;

  localparam logic [2:0] E_NONE      = 3'd0;
  localparam logic [2:0] E_SHORT_KEY = 3'd1;
  localparam logic [2:0] E_SHORT_MSG = 3'd2;
  localparam logic [2:0] E_COLLISION = 3'd3;
  localparam logic [2:0] E_ENC_TMO   = 3'd4;
  localparam logic [2:0] E_SER_STALL = 3'd5;

  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

  logic [2:0]    state_q, state_d;
  logic [2:0]    err_code_q, err_d;
  logic          key_flag_q, msg_flag_q;
  logic          key_fall, msg_fall;
  logic [TW-1:0] tmr_q;
  logic [UW-1:0] use_q, use_inc;
  logic          ser_seen_q;
  logic          enc_start_q, ser_start_q;
  logic          clr_use;
  logic          state_chg;

  assign key_fall  = key_flag_q & ~key_flag_i;
  assign msg_fall  = msg_flag_q & ~msg_flag_i;
  assign use_inc   = (use_q == '1) ? use_q : use_q + UW'(1);
  assign state_chg = (state_d != state_q);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    err_d   = err_code_q;
    clr_use = 1'b0;
    if (state_q != S_ERROR && key_flag_i && msg_flag_i) begin
      state_d = S_ERROR;
      err_d   = E_COLLISION;
    end else if (clr_i) begin
      state_d = S_IDLE;
      err_d   = E_NONE;
      clr_use = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:     if (key_flag_i) state_d = S_LOAD_KEY;
        S_LOAD_KEY: if (key_fall) begin
          if (key_cnt_i == KCW'(KEY_SIZE)) state_d = S_WAIT_MSG;
          else begin
            state_d = S_ERROR;
            err_d   = E_SHORT_KEY;
          end
        end
        S_WAIT_MSG: begin
          if (msg_flag_i)      state_d = S_LOAD_MSG;
          else if (key_flag_i) state_d = S_LOAD_KEY;
        end
        S_LOAD_MSG: if (msg_fall) begin
          if (msg_cnt_i == MCW'(MSG_SIZE)) state_d = S_ENCRYPT;
          else begin
            state_d = S_ERROR;
            err_d   = E_SHORT_MSG;
          end
        end
        S_ENCRYPT: begin
          // done beats a simultaneous timeout
          if (enc_done_i) state_d = S_SEND;
          else if (tmr_q == TMR_LAST) begin
            state_d = S_ERROR;
            err_d   = E_ENC_TMO;
          end
        end
        S_SEND: begin
          if (ser_seen_q && !ser_busy_i) state_d = S_DONE;
          else if (!ser_seen_q && !ser_busy_i && tmr_q == TMR_LAST) begin
            state_d = S_ERROR;
            err_d   = E_SER_STALL;
          end
        end
        S_DONE: begin
`ifdef XSC_KEY_ROTATE_EN
          if (use_inc == UW'(KEY_USES)) state_d = S_IDLE;
          else                          state_d = S_WAIT_MSG;
`else
          state_d = S_WAIT_MSG;
`endif
        end
        S_ERROR: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; ena=0 freezes every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      err_code_q  <= E_NONE;
      key_flag_q  <= 1'b0;
      msg_flag_q  <= 1'b0;
      tmr_q       <= '0;
      use_q       <= '0;
      ser_seen_q  <= 1'b0;
      enc_start_q <= 1'b0;
      ser_start_q <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      err_code_q  <= err_d;
      key_flag_q  <= key_flag_i;
      msg_flag_q  <= msg_flag_i;
      enc_start_q <= state_chg && (state_d == S_ENCRYPT);
      ser_start_q <= state_chg && (state_d == S_SEND);

      // shared timer: ENCRYPT done-wait and SEND busy-wait, restarted on every state change
      if (state_chg)
        tmr_q <= '0;
      else if (state_q == S_ENCRYPT || state_q == S_SEND)
        tmr_q <= tmr_q + TW'(1);

      if (state_chg)
        ser_seen_q <= 1'b0;
      else if (state_q == S_SEND && ser_busy_i)
        ser_seen_q <= 1'b1;

      if (clr_use || (state_chg && state_d == S_LOAD_KEY))
        use_q <= '0;
      else if (state_q == S_DONE)
        use_q <= use_inc;
    end
  end

  assign enc_start_o = enc_start_q & ena;
  assign ser_start_o = ser_start_q & ena;
  assign done_o      = (state_q == S_DONE) & ena;
  assign err_o       = (state_q == S_ERROR);
  assign err_code_o  = err_code_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_xor_session_ctrl.sv
// Directed self-checking bench for xor_session_ctrl; honours XSC_KEY_ROTATE_EN if defined.
module tb_xor_session_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena, clr_i, key_flag_i, msg_flag_i, enc_done_i, ser_busy_i;
  logic [3:0] key_cnt_i;
  logic [6:0] msg_cnt_i;
  logic       enc_start_o, ser_start_o, done_o, err_o;
  logic [2:0] err_code_o, state_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n_enc = 0, n_ser = 0, n_done = 0;

  xor_session_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr_i(clr_i),
    .key_flag_i(key_flag_i), .msg_flag_i(msg_flag_i),
    .key_cnt_i(key_cnt_i), .msg_cnt_i(msg_cnt_i),
    .enc_done_i(enc_done_i), .ser_busy_i(ser_busy_i),
    .enc_start_o(enc_start_o), .ser_start_o(ser_start_o), .done_o(done_o),
    .err_o(err_o), .err_code_o(err_code_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (enc_start_o) n_enc++;
    if (ser_start_o) n_ser++;
    if (done_o)      n_done++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse_counts();
    n_enc = 0; n_ser = 0; n_done = 0;
  endtask

  task automatic do_reset();
    ena = 1'b1; clr_i = 1'b0; key_flag_i = 1'b0; msg_flag_i = 1'b0;
    key_cnt_i = '0; msg_cnt_i = '0; enc_done_i = 1'b0; ser_busy_i = 1'b0;
    rst_n = 1'b0;
    #7 rst_n = 1'b1;
    step(1);
    clear_pulse_counts();
  endtask

  // From IDLE/WAIT_MSG: good key load, ends in WAIT_MSG
  task automatic load_key_ok();
    key_flag_i = 1'b1; key_cnt_i = 4'd0; step(1);
    key_cnt_i = 4'd8; key_flag_i = 1'b0; step(1);
  endtask

  // From WAIT_MSG: good message load, ends in first ENCRYPT cycle
  task automatic load_msg_ok();
    msg_flag_i = 1'b1; msg_cnt_i = 7'd0; step(1);
    msg_cnt_i = 7'd64; msg_flag_i = 1'b0; step(1);
  endtask

  task automatic run_session();
    load_msg_ok();
    enc_done_i = 1'b1; step(1);
    enc_done_i = 1'b0; ser_busy_i = 1'b1; step(3);
    ser_busy_i = 1'b0; step(1);
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1; clr_i = 1'b0; key_flag_i = 1'b0; msg_flag_i = 1'b0;
    key_cnt_i = '0; msg_cnt_i = '0; enc_done_i = 1'b0; ser_busy_i = 1'b0;
    #3;
    if (state_o !== 3'd0) $display("FAIL reset_state got %0d exp 0", state_o); else pass_cnt++;
    total_cnt++;
    if ({enc_start_o, ser_start_o, done_o, err_o, err_code_o} !== 7'd0)
      $display("FAIL reset_outputs got %b exp 0000000", {enc_start_o, ser_start_o, done_o, err_o, err_code_o});
    else pass_cnt++;
    total_cnt++;
    do_reset();
    msg_flag_i = 1'b1; step(2); msg_flag_i = 1'b0;
    if (state_o !== 3'd0) $display("FAIL idle_msg_ignored got %0d exp 0", state_o); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_happy_path();
    do_reset();
    key_flag_i = 1'b1; step(1);
    if (state_o !== 3'd1) $display("FAIL hp_load_key got %0d exp 1", state_o); else pass_cnt++;
    total_cnt++;
    key_cnt_i = 4'd8; key_flag_i = 1'b0; step(1);
    if (state_o !== 3'd2) $display("FAIL hp_wait_msg got %0d exp 2", state_o); else pass_cnt++;
    total_cnt++;
    msg_flag_i = 1'b1; step(1);
    if (state_o !== 3'd3) $display("FAIL hp_load_msg got %0d exp 3", state_o); else pass_cnt++;
    total_cnt++;
    msg_cnt_i = 7'd64; msg_flag_i = 1'b0; step(1);
    if ({state_o, enc_start_o} !== {3'd4, 1'b1})
      $display("FAIL hp_encrypt_start got state %0d start %b exp 4 1", state_o, enc_start_o);
    else pass_cnt++;
    total_cnt++;
    step(2);
    enc_done_i = 1'b1; step(1);
    if ({state_o, ser_start_o} !== {3'd5, 1'b1})
      $display("FAIL hp_send_start got state %0d start %b exp 5 1", state_o, ser_start_o);
    else pass_cnt++;
    total_cnt++;
    enc_done_i = 1'b0; step(1);
    ser_busy_i = 1'b1; step(64);
    if (state_o !== 3'd5) $display("FAIL hp_send_busy got %0d exp 5", state_o); else pass_cnt++;
    total_cnt++;
    ser_busy_i = 1'b0; step(1);
    if ({state_o, done_o} !== {3'd6, 1'b1})
      $display("FAIL hp_done got state %0d done %b exp 6 1", state_o, done_o);
    else pass_cnt++;
    total_cnt++;
    step(1);
    if ({state_o, err_o} !== {3'd2, 1'b0})
      $display("FAIL hp_back_to_wait got state %0d err %b exp 2 0", state_o, err_o);
    else pass_cnt++;
    total_cnt++;
    if ({n_enc, n_ser, n_done} !== {32'd1, 32'd1, 32'd1})
      $display("FAIL hp_pulse_counts got %0d %0d %0d exp 1 1 1", n_enc, n_ser, n_done);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_short_key();
    do_reset();
    key_flag_i = 1'b1; step(1);
    key_cnt_i = 4'd5; key_flag_i = 1'b0; step(1);
    if ({state_o, err_o, err_code_o} !== {3'd7, 1'b1, 3'd1})
      $display("FAIL short_key got state %0d err %b code %0d exp 7 1 1", state_o, err_o, err_code_o);
    else pass_cnt++;
    total_cnt++;
    clr_i = 1'b1; step(1); clr_i = 1'b0;
    if ({state_o, err_o, err_code_o} !== {3'd0, 1'b0, 3'd0})
      $display("FAIL short_key_clr got state %0d err %b code %0d exp 0 0 0", state_o, err_o, err_code_o);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_short_msg();
    do_reset();
    load_key_ok();
    msg_flag_i = 1'b1; step(1);
    msg_cnt_i = 7'd63; msg_flag_i = 1'b0; step(1);
    if ({state_o, err_code_o} !== {3'd7, 3'd2})
      $display("FAIL short_msg got state %0d code %0d exp 7 2", state_o, err_code_o);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_collision();
    do_reset();
    load_key_ok();
    key_flag_i = 1'b1; msg_flag_i = 1'b1; step(1);
    if ({state_o, err_code_o} !== {3'd7, 3'd3})
      $display("FAIL collision got state %0d code %0d exp 7 3", state_o, err_code_o);
    else pass_cnt++;
    total_cnt++;
    step(3);
    if ({state_o, err_code_o} !== {3'd7, 3'd3})
      $display("FAIL error_hold got state %0d code %0d exp 7 3", state_o, err_code_o);
    else pass_cnt++;
    total_cnt++;
    key_flag_i = 1'b0; msg_flag_i = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    load_key_ok();
    load_msg_ok();
    step(254);
    if (state_o !== 3'd4) $display("FAIL tmo_before got %0d exp 4", state_o); else pass_cnt++;
    total_cnt++;
    step(1);
    if ({state_o, err_code_o} !== {3'd7, 3'd4})
      $display("FAIL tmo_error got state %0d code %0d exp 7 4", state_o, err_code_o);
    else pass_cnt++;
    total_cnt++;
    clr_i = 1'b1; step(1); clr_i = 1'b0;
    load_key_ok();
    load_msg_ok();
    step(254);
    enc_done_i = 1'b1; step(1); enc_done_i = 1'b0;
    if ({state_o, err_o} !== {3'd5, 1'b0})
      $display("FAIL tmo_done_wins got state %0d err %b exp 5 0", state_o, err_o);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_ser_stall();
    do_reset();
    load_key_ok();
    load_msg_ok();
    enc_done_i = 1'b1; step(1); enc_done_i = 1'b0;
    step(254);
    if (state_o !== 3'd5) $display("FAIL stall_before got %0d exp 5", state_o); else pass_cnt++;
    total_cnt++;
    step(1);
    if ({state_o, err_code_o} !== {3'd7, 3'd5})
      $display("FAIL stall_error got state %0d code %0d exp 7 5", state_o, err_code_o);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    load_key_ok();
    load_msg_ok();
    clear_pulse_counts();
    enc_done_i = 1'b1; step(1); enc_done_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    if ({state_o, ser_start_o, err_o, err_code_o} !== 7'd0)
      $display("FAIL async_reset got state %0d ser %b err %b code %0d exp all 0",
               state_o, ser_start_o, err_o, err_code_o);
    else pass_cnt++;
    total_cnt++;
    #1 rst_n = 1'b1;
    step(3);
    if ({state_o, n_ser} !== {3'd0, 32'd0})
      $display("FAIL no_reissue got state %0d ser pulses %0d exp 0 0", state_o, n_ser);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_ena_freeze();
    do_reset();
    load_key_ok();
    msg_flag_i = 1'b1; step(1);
    msg_cnt_i = 7'd64; msg_flag_i = 1'b0;
    clear_pulse_counts();
    step(1);
    ena = 1'b0;
    #1;
    if (enc_start_o !== 1'b0) $display("FAIL ena_force got %b exp 0", enc_start_o); else pass_cnt++;
    total_cnt++;
    step(10);
    if ({state_o, n_enc} !== {3'd4, 32'd0})
      $display("FAIL ena_hold got state %0d pulses %0d exp 4 0", state_o, n_enc);
    else pass_cnt++;
    total_cnt++;
    ena = 1'b1;
    step(254);
    if (state_o !== 3'd4) $display("FAIL ena_tmr_frozen got %0d exp 4", state_o); else pass_cnt++;
    total_cnt++;
    step(1);
    if ({state_o, err_code_o, n_enc} !== {3'd7, 3'd4, 32'd1})
      $display("FAIL ena_tmo got state %0d code %0d pulses %0d exp 7 4 1", state_o, err_code_o, n_enc);
    else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_after;
    logic [2:0] exp_msg;
    do_reset();
    load_key_ok();
    for (int i = 0; i < 4; i++) run_session();
`ifdef XSC_KEY_ROTATE_EN
    exp_after = 3'd0;
    exp_msg   = 3'd0;
`else
    exp_after = 3'd2;
    exp_msg   = 3'd3;
`endif
    if ({state_o, n_done} !== {exp_after, 32'd4})
      $display("FAIL b2b_after_four got state %0d done %0d exp %0d 4", state_o, n_done, exp_after);
    else pass_cnt++;
    total_cnt++;
    msg_flag_i = 1'b1; step(1); msg_flag_i = 1'b0;
    if (state_o !== exp_msg) $display("FAIL b2b_msg_flag got %0d exp %0d", state_o, exp_msg); else pass_cnt++;
    total_cnt++;
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_short_key();
    test_short_msg();
    test_collision();
    test_timeout();
    test_ser_stall();
    test_mid_reset();
    test_ena_freeze();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
